adc_sample_ctrl: RTL

- Sequences one serial 12-bit ADC conversion frame: drives cs_n and sclk to the converter.
- Gates the existing MSB-first shift-in register through shift_ena and shift_rst_n.
- Latches the finished 12-bit word and hands it to the downstream video/visual pipeline on a valid/ready handshake.
- Supports periodic (free-running) and single-shot sampling, with sticky overrun reporting.

---
 rtl/adc_pkg.sv | 23 ++
 rtl/sclk_gen.sv | 41 ++++
 rtl/adc_sample_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the serial ADC sampling controller and its helpers.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    CAPTURE,
    QUIET
  } state_t;

  localparam int FRAME_BITS_DEF = 16;
  localparam int LEAD_BITS_DEF  = 4;
  localparam int DATA_BITS_DEF  = 12;

  // Shortest start-to-start spacing that still leaves the full quiet gap.
  function automatic int min_sample_period(input int clk_div, input int frame_bits,
                                           input int quiet_cycles);
    return clk_div * (2 * frame_bits + 2) + 2 + quiet_cycles;
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// Serial clock generator: idles high, runs low-then-high half periods of CLK_DIV
// clk cycles while run is held, and strobes rise in the cycle sclk goes high.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_DIV);

  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nxt;
  logic          active;

  // run is a look-ahead: pos_nxt is the phase of the cycle about to start.
  always_comb begin
    pos_nxt = '0;
    if (run && active && (pos != LAST)) pos_nxt = pos + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos    <= '0;
      active <= 1'b0;
      sclk   <= 1'b1;
      rise   <= 1'b0;
    end else begin
      pos    <= pos_nxt;
      active <= run;
      sclk   <= !(run && (pos_nxt < HALF));
      rise   <= run && (pos_nxt == HALF);
    end
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Serial ADC frame sequencer: drives cs_n/sclk, gates the external shift-in
// register and hands each finished word downstream on a valid/ready handshake.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int FRAME_BITS    = FRAME_BITS_DEF,
  parameter int LEAD_BITS     = LEAD_BITS_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int QUIET_CYCLES  = 8,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 trig,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 shift_ena,
  output logic                 shift_rst_n,
  input  logic [DATA_BITS-1:0] shift_data,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int SHIFT_LEN  = 2 * CLK_DIV * FRAME_BITS;
  localparam int MIN_PERIOD = min_sample_period(CLK_DIV, FRAME_BITS, QUIET_CYCLES);
  // A period shorter than one frame would eat the quiet gap; stretch it instead.
  localparam int PERIOD     = (SAMPLE_PERIOD < MIN_PERIOD) ? MIN_PERIOD : SAMPLE_PERIOD;
  localparam int CW         = $clog2(SHIFT_LEN + QUIET_CYCLES + 1);
  localparam int PCW        = $clog2(PERIOD);
  localparam int BW         = $clog2(FRAME_BITS + 1);

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic [PCW-1:0] pcnt;
  logic [BW-1:0]  bit_cnt;
  logic           period_tick;
  logic           start;
  logic           seg_done;
  logic           sclk_rise;
  logic           cs_n_nxt;
  logic           busy_nxt;
  logic           shift_rst_n_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              pcnt <= '0;
    else if (!en)                          pcnt <= '0;
    else if (pcnt == PCW'(PERIOD - 1))     pcnt <= '0;
    else                                   pcnt <= pcnt + 1'b1;
  end

  assign period_tick = en && (pcnt == '0);
  assign start       = (en && period_tick) || trig;

  always_comb begin
    seg_done = 1'b0;
    unique case (state)
      SETUP:   seg_done = (cnt == CW'(CLK_DIV - 1));
      SHIFT:   seg_done = (cnt == CW'(SHIFT_LEN - 1));
      HOLD:    seg_done = (cnt == CW'(CLK_DIV - 1));
      CAPTURE: seg_done = 1'b1;
      QUIET:   seg_done = (cnt == CW'(QUIET_CYCLES - 1));
      default: seg_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if ((nxt != state) || (state == IDLE)) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start)    nxt = SETUP;
      SETUP:   if (seg_done) nxt = SHIFT;
      SHIFT:   if (seg_done) nxt = HOLD;
      HOLD:    if (seg_done) nxt = CAPTURE;
      CAPTURE:               nxt = QUIET;
      QUIET:   if (seg_done) nxt = IDLE;
      default:               nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_comb begin
    cs_n_nxt        = !(nxt inside {SETUP, SHIFT, HOLD});
    busy_nxt        = (nxt != IDLE);
    shift_rst_n_nxt = !((nxt == SETUP) && (state != SETUP));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      shift_rst_n <= 1'b0;
    end else begin
      cs_n        <= cs_n_nxt;
      busy        <= busy_nxt;
      shift_rst_n <= shift_rst_n_nxt;
    end
  end

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk (clk),
    .rst (rst),
    .run (nxt == SHIFT),
    .sclk(sclk),
    .rise(sclk_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                bit_cnt <= '0;
    else if (state != SHIFT) bit_cnt <= '0;
    else if (sclk_rise)      bit_cnt <= bit_cnt + 1'b1;
  end

  // Leading zero bits still clock the converter but are kept out of the word.
  assign shift_ena = sclk_rise && (bit_cnt >= BW'(LEAD_BITS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if ((state == CAPTURE) && (!dout_valid || dout_ready)) begin
        dout       <= shift_data;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (clr_overrun)
        overrun <= 1'b0;
      else if ((state == CAPTURE) && dout_valid && !dout_ready)
        overrun <= 1'b1;
    end
  end

endmodule
